// File: rtl/serpent_sbox_layer_seq_if.sv
// Handshake and data bundle for the multi-cycle Serpent S-box layer.
// The member names match the original flat port list, so call sites only
// have to change how the ports are connected, not what the signals are called.
interface serpent_sbox_layer_seq_if;
  logic         i_valid;
  logic         o_ready;
  logic         i_decrypt;
  logic [2:0]   i_sbox_index;
  logic [31:0]  i_word_0;
  logic [31:0]  i_word_1;
  logic [31:0]  i_word_2;
  logic [31:0]  i_word_3;
  logic         o_valid;
  logic         i_ready;
  logic         i_flush;
  logic [31:0]  o_word_0;
  logic [31:0]  o_word_1;
  logic [31:0]  o_word_2;
  logic [31:0]  o_word_3;
  logic [127:0] o_data;

  modport master (
    output i_valid, i_decrypt, i_sbox_index,
    output i_word_0, i_word_1, i_word_2, i_word_3,
    output i_ready, i_flush,
    input  o_ready, o_valid,
    input  o_word_0, o_word_1, o_word_2, o_word_3, o_data
  );

  modport slave (
    input  i_valid, i_decrypt, i_sbox_index,
    input  i_word_0, i_word_1, i_word_2, i_word_3,
    input  i_ready, i_flush,
    output o_ready, o_valid,
    output o_word_0, o_word_1, o_word_2, o_word_3, o_data
  );
endinterface

// File: rtl/serpent_sbox_layer_seq.sv
// Multi-cycle Serpent S-box layer (forward S0..S7 and their inverses) on a
// 128-bit bitsliced state. LANES 4-bit columns are substituted per cycle, so a
// block takes 32/LANES cycles between acceptance and a valid result.
// Column i is {w3[i],w2[i],w1[i],w0[i]}; S-box output bit k lands in word k, bit i.
module serpent_sbox_layer_seq #(
  parameter int LANES = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  serpent_sbox_layer_seq_if.slave bus
);

  localparam int BEATS = (LANES > 0) ? (32 / LANES) : 1;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 &&
      LANES != 16 && LANES != 32) begin : g_bad_lanes
    $error("serpent_sbox_layer_seq: LANES must be 1, 2, 4, 8, 16 or 32");
  end

  // One 64-bit constant per table, entry v in bits [4v+3:4v].
  // Index is {decrypt, sbox_index}: 0..7 forward S0..S7, 8..15 InvS0..InvS7.
  localparam logic [63:0] SBOX [16] = '{
    64'hC90724DE_B56A1F83,  // S0
    64'h43D68EB1_A50972CF,  // S1
    64'h25B04E1D_FAC39768,  // S2
    64'hE57A421D_369C8BF0,  // S3
    64'hD7E9A452_6B0C38F1,  // S4
    64'h176D8E30_C9A4B25F,  // S5
    64'h0A3DF19E_B6485C27,  // S6
    64'h6539AC47_B28E0FD1,  // S7
    64'h289F74E1_C56A0B3D,  // InvS0
    64'h0AD1974B_3C6FE285,  // InvS1
    64'h7A85D630_21EB4F9C,  // InvS2
    64'h1F842C53_D6EB7A90,  // InvS3
    64'h1DF46BC2_E79A3805,  // InvS4
    64'h0AC7356B_ED1492F8,  // InvS5
    64'hB8C27E94_0635D1AF,  // InvS6
    64'h241A7BC5_8FE9D603   // InvS7
  };

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          valid_q, valid_d;
  logic          dec_q, dec_d;
  logic [2:0]    idx_q, idx_d;
  logic [31:0]   win_q [4];
  logic [31:0]   win_d [4];
  logic [31:0]   res_q [4];
  logic [31:0]   res_d [4];

  logic          accept;
  logic [3:0]    tbl;
  logic [4:0]    col;
  logic [3:0]    nib;
  logic [3:0]    sub;

  // Ready is combinational so a DONE block can hand over and accept in one cycle.
  assign bus.o_ready = !i_rst && !bus.i_flush &&
                       ((state_q == IDLE) || ((state_q == DONE) && bus.i_ready));

  assign bus.o_valid  = valid_q;
  assign bus.o_word_0 = res_q[0];
  assign bus.o_word_1 = res_q[1];
  assign bus.o_word_2 = res_q[2];
  assign bus.o_word_3 = res_q[3];
  assign bus.o_data   = {res_q[3], res_q[2], res_q[1], res_q[0]};

  // Next-state logic: flush overrides everything, then IDLE/BUSY/DONE sequencing.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    dec_d   = dec_q;
    idx_d   = idx_q;
    win_d   = win_q;
    res_d   = res_q;
    accept  = 1'b0;
    tbl     = {dec_q, idx_q};
    col     = '0;
    nib     = '0;
    sub     = '0;

    if (bus.i_flush) begin
      state_d = IDLE;
      valid_d = 1'b0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.i_valid) accept = 1'b1;
        end
        BUSY: begin
          for (int unsigned l = 0; l < LANES; l++) begin
            col = 5'((32'(cnt_q) * LANES) + l);
            nib = {win_q[3][col], win_q[2][col], win_q[1][col], win_q[0][col]};
            sub = SBOX[tbl][{nib, 2'b00} +: 4];
            res_d[0][col] = sub[0];
            res_d[1][col] = sub[1];
            res_d[2][col] = sub[2];
            res_d[3][col] = sub[3];
          end
          // With a single beat the counter simply wraps; it is cleared on the next accept.
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) begin
            state_d = DONE;
            valid_d = 1'b1;
          end
        end
        DONE: begin
          if (bus.i_ready) begin
            valid_d = 1'b0;
            if (bus.i_valid) accept = 1'b1;
            else             state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      endcase
    end

    if (accept) begin
      win_d[0] = bus.i_word_0;
      win_d[1] = bus.i_word_1;
      win_d[2] = bus.i_word_2;
      win_d[3] = bus.i_word_3;
      dec_d    = bus.i_decrypt;
      idx_d    = bus.i_sbox_index;
      cnt_d    = '0;
      state_d  = BUSY;
    end
  end

  // State, latched block and result registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      dec_q   <= 1'b0;
      idx_q   <= '0;
      win_q   <= '{default: '0};
      res_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      dec_q   <= dec_d;
      idx_q   <= idx_d;
      win_q   <= win_d;
      res_q   <= res_d;
    end
  end

endmodule
